mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, 64-bit-wide, byte-enabled synchronous RAM between the instruction-fetch requester and the load/store requester.
- One access per cycle, fully pipelined.
- Data accesses have priority. A starvation guard forces a fetch grant after STARVE_MAX consecutive contested data grants.
- Routes each 1-cycle-latency read response back to the requester that issued it.
- Sits between the core's fetch/memory stages and the unified RAM macro.

Parameters:
- ADDR_W, 14, doubleword address width (byte address / 8)
- DATA_W, 64, RAM word width
- BE_W, 8, byte-enable width (DATA_W/8)
- STARVE_MAX, 4, consecutive contested data grants before fetch is forced; must be >= 1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch doubleword address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held with d_addr/d_we/d_wdata stable until d_gnt
- d_addr  in  ADDR_W  data doubleword address
- d_we  in  BE_W  byte write enables; all-zero means read
- d_wdata  in  DATA_W  store data, already lane-aligned
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  load data valid, or store acknowledge
- d_rdata  out  DATA_W  load data; zero on a store acknowledge
- ram_en  out  1  RAM access enable
- ram_we  out  BE_W  RAM byte write enables
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high. All state updates on the rising edge of clk.
- Values during and after reset:
  - While rst is high, if_gnt, d_gnt and ram_en are 0.
  - In the cycle after rst deasserts, if_rvalid and d_rvalid are 0.
  - Reset clears starve_cnt to 0 and resp_owner to NONE.
  - if_rdata and d_rdata read 0 whenever their rvalid is 0.
- Grant (combinational, per cycle, only when rst=0):
  - force = (starve_cnt == STARVE_MAX).
  - d_gnt = d_req & ~(if_req & force).
  - if_gnt = if_req & ~d_gnt.
  - Exactly one grant or none. Never both.
- RAM drive:
  - ram_en = if_gnt | d_gnt.
  - On a data grant: ram_addr = d_addr, ram_we = d_we, ram_wdata = d_wdata.
  - On a fetch grant: ram_addr = if_addr, ram_we = 0, ram_wdata = 0.
  - Idle cycle: all outputs 0.
- Response routing:
  - Registered resp_owner ∈ {NONE, IF, D_RD, D_WR}, loaded every cycle from the current grant.
  - Next cycle: IF → if_rvalid=1, if_rdata=ram_rdata. D_RD → d_rvalid=1, d_rdata=ram_rdata. D_WR → d_rvalid=1, d_rdata=0. NONE → both rvalid 0.
  - Latency is exactly 1 cycle from grant to rvalid. Back-to-back grants give back-to-back responses, with no bubble.
- Starvation counter (starve_cnt, width clog2(STARVE_MAX+1)):
  - Cycle with d_gnt & if_req: increment, saturating at STARVE_MAX.
  - Cycle with if_gnt: clear to 0.
  - Cycle with if_req=0: clear to 0.
  - Otherwise: hold.
- Boundary conditions:
  - Both requests raised the same cycle with starve_cnt < STARVE_MAX: data wins.
  - Fetch-only or data-only traffic: granted every cycle.
  - A requester dropping req before its grant is legal. Nothing is issued for it.
  - rst asserted with a response pending: the response is dropped. rvalid is 0 in the cycle after reset, and no stale data appears later.
  - Store followed by a load to the same address on consecutive cycles: the load returns the stored bytes. RAM write-first behaviour is required; the arbiter adds no forwarding.

Test Plan:
- Fetch only: if_req=1 for 3 cycles, if_addr=0x10,0x11,0x12 → if_gnt=1 every cycle; if_rvalid=1 one cycle later each time; data equals the preloaded RAM words; d_rvalid=0 throughout.
- Contention: both requests continuous, STARVE_MAX=4 → grant sequence D,D,D,D,IF,D,D,D,D,IF; starve_cnt is 4 when IF is granted and 0 after.
- Store then load: d_we=0x0F, d_addr=0x20, d_wdata=0x0000_0000_DEAD_BEEF, then a read of 0x20 → store ack with d_rdata=0; read returns low word 0xDEADBEEF and the upper word unchanged from preload.
- Fetch withdraw: if_req=1 for 2 cycles while d_req=1, then if_req=0 → starve_cnt clears to 0; no fetch access issued; if_rvalid stays 0.
- Reset mid-flight: grant a read of 0x05, assert rst on the next edge → if_rvalid and d_rvalid are 0 in the cycle after reset; ram_en=0 while rst=1; starve_cnt=0.
- Interleaved pipeline: alternating IF@0x1 and D read@0x2 each cycle, no contention → every response arrives exactly 1 cycle after its grant on the correct port, with no bubble cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port, byte-enabled synchronous RAM.
// Data accesses win by default; a starvation counter forces a fetch grant
// after STARVE_MAX consecutive contested data grants. Read responses come
// back one cycle after the grant and are steered to the issuing requester.
//
// Handshake: a requester raises req with its address/data stable and holds
// them until the cycle its gnt is high; that cycle is the transfer. rvalid is
// a one-cycle pulse exactly one cycle after the grant, with no back-pressure.
module mem_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 64,
  parameter int BE_W       = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [BE_W-1:0]   d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_en,
  output logic [BE_W-1:0]   ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  // Who owns the RAM response arriving next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D_RD = 2'd2,
    OWN_D_WR = 2'd3
  } owner_e;

  owner_e           resp_owner;
  owner_e           owner_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             force_if;

  // Grant decision: data first unless fetch has been starved long enough.
  always_comb begin
    force_if = (starve_cnt == CNT_MAX);
    d_gnt    = 1'b0;
    if_gnt   = 1'b0;
    if (!rst) begin
      d_gnt  = d_req & ~(if_req & force_if);
      if_gnt = if_req & ~d_gnt;
    end
  end

  // Drive the RAM from whichever requester holds the grant; zeros when idle.
  always_comb begin
    ram_en    = if_gnt | d_gnt;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (d_gnt) begin
      ram_we    = d_we;
      ram_addr  = d_addr;
      ram_wdata = d_wdata;
    end else if (if_gnt) begin
      ram_addr  = if_addr;
    end
  end

  // Next response owner and next starvation count from this cycle's grant.
  always_comb begin
    owner_nxt = OWN_NONE;
    if (if_gnt) begin
      owner_nxt = OWN_IF;
    end else if (d_gnt) begin
      owner_nxt = (|d_we) ? OWN_D_WR : OWN_D_RD;
    end
    cnt_nxt = starve_cnt;
    if (!if_req || if_gnt) begin
      cnt_nxt = '0;
    end else if (d_gnt && (starve_cnt != CNT_MAX)) begin
      cnt_nxt = starve_cnt + CNT_W'(1);
    end
  end

  // State registers: response owner and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_owner <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      resp_owner <= owner_nxt;
      starve_cnt <= cnt_nxt;
    end
  end

  // Steer the RAM read data to its owner; store acks return zero data.
  always_comb begin
    if_rvalid = (resp_owner == OWN_IF);
    d_rvalid  = (resp_owner == OWN_D_RD) || (resp_owner == OWN_D_WR);
    if_rdata  = (resp_owner == OWN_IF)   ? ram_rdata : '0;
    d_rdata   = (resp_owner == OWN_D_RD) ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a byte-enabled write-first RAM model, a
// reference model of the arbitration rules and memory contents, directed
// scenarios followed by randomized traffic.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 64;
  localparam int BE_W       = 8;
  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [BE_W-1:0]   d_we;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              ram_en;
  logic [BE_W-1:0]   ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // ---------------- RAM model (write-first) ----------------
  function automatic logic [63:0] init_word(input int a);
    return {32'h1000_0000 + 32'(a), 32'hC0DE_0000 ^ 32'(a * 3)};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_w,
                                        input logic [63:0] wd,
                                        input logic [7:0] we);
    logic [63:0] w;
    w = old_w;
    for (int b = 0; b < 8; b++) if (we[b]) w[b*8 +: 8] = wd[b*8 +: 8];
    return w;
  endfunction

  logic [DATA_W-1:0] ram_arr [0:(1<<ADDR_W)-1];

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram_arr[i] = init_word(i);
  end

  // Unaccessed cycles return garbage so unmasked read data gets noticed.
  always @(posedge clk) begin
    logic [63:0] w;
    if (ram_en) begin
      w = merge(ram_arr[ram_addr], ram_wdata, ram_we);
      ram_arr[ram_addr] <= w;
      ram_rdata <= w;
    end else begin
      ram_rdata <= {$urandom, $urandom};
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] exp_q[$];
  int                kind_q[$];   // 0 none, 1 fetch response, 2 data response
  logic [63:0]       ref_mem [int];
  int                model_cnt;   // contested data wins since fetch last served
  logic              g_if;
  logic              g_d;

  function automatic logic [63:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: called just after a falling edge, returns after the next.
  task automatic cyc(input logic ir, input logic [ADDR_W-1:0] ia,
                     input logic dr, input logic [ADDR_W-1:0] da,
                     input logic [BE_W-1:0] we, input logic [DATA_W-1:0] wd,
                     input logic r);
    int kind;
    logic [63:0] data;
    logic fetch_owed;
    rst = r; if_req = ir; if_addr = ia; d_req = dr; d_addr = da;
    d_we = we; d_wdata = wd;
    #1;
    if (r) begin
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_ram_en", ram_en, 0);
      exp_q.delete();
      kind_q.delete();
      kind_q.push_back(0);
      exp_q.push_back('0);
      model_cnt = 0;
      g_if = 0;
      g_d = 0;
    end else begin
      kind = 0;
      data = '0;
      if (kind_q.size() > 0) begin
        kind = kind_q.pop_front();
        data = exp_q.pop_front();
      end
      chk("if_rvalid", if_rvalid, kind == 1);
      chk("if_rdata", if_rdata, (kind == 1) ? data : 64'h0);
      chk("d_rvalid", d_rvalid, kind == 2);
      chk("d_rdata", d_rdata, (kind == 2) ? data : 64'h0);
      chk("starve_cnt", 64'(dut.starve_cnt), 64'(model_cnt));
      // Fetch is owed the RAM once it has lost STARVE_MAX contested cycles.
      fetch_owed = ir && (model_cnt >= STARVE_MAX);
      g_d  = dr && !fetch_owed;
      g_if = ir && !g_d;
      chk("d_gnt", d_gnt, g_d);
      chk("if_gnt", if_gnt, g_if);
      chk("ram_en", ram_en, g_d || g_if);
      chk("ram_addr", ram_addr, g_d ? da : (g_if ? ia : '0));
      chk("ram_we", ram_we, g_d ? we : '0);
      chk("ram_wdata", ram_wdata, g_d ? wd : '0);
      if (g_d && we != 0) begin
        ref_mem[int'(da)] = merge(ref_read(int'(da)), wd, we);
        kind_q.push_back(2);
        exp_q.push_back('0);
      end else if (g_d) begin
        kind_q.push_back(2);
        exp_q.push_back(ref_read(int'(da)));
      end else if (g_if) begin
        kind_q.push_back(1);
        exp_q.push_back(ref_read(int'(ia)));
      end else begin
        kind_q.push_back(0);
        exp_q.push_back('0);
      end
      if (!ir || g_if) model_cnt = 0;
      else if (model_cnt < STARVE_MAX) model_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, '0, 0, '0, '0, '0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0]  seq;
    logic [63:0] w;
    logic        pi, pd;
    logic [ADDR_W-1:0] ai, ad;
    logic [BE_W-1:0]   we_r;
    logic [DATA_W-1:0] wd_r;
    model_cnt = 0;
    g_if = 0;
    g_d = 0;
    rst = 1; if_req = 0; if_addr = '0; d_req = 0; d_addr = '0;
    d_we = '0; d_wdata = '0;
    @(negedge clk);

    // Reset with both requests raised: nothing may be granted.
    cyc(1, 14'h3, 1, 14'h4, '0, '0, 1);
    cyc(1, 14'h3, 1, 14'h4, '0, '0, 1);
    idle();
    chk("post_rst_starve", 64'(dut.starve_cnt), 0);

    // Fetch only.
    cyc(1, 14'h10, 0, '0, '0, '0, 0);
    cyc(1, 14'h11, 0, '0, '0, '0, 0);
    cyc(1, 14'h12, 0, '0, '0, '0, 0);
    w = init_word(14'h12);
    chk("fetch_last_data", if_rdata, w);
    idle();

    // Contention: fetch held on one address until granted.
    for (int i = 0; i < 10; i++) begin
      cyc(1, 14'h40, 1, 14'(14'h80 + i), '0, '0, 0);
      seq[i] = g_if;
    end
    chk("contention_seq", 64'(seq), 64'(10'b10_0001_0000));
    idle();

    // Store then load at the same address.
    cyc(0, '0, 1, 14'h20, 8'h0F, 64'h0000_0000_DEAD_BEEF, 0);
    chk("store_ack_data", d_rdata, 0);
    cyc(0, '0, 1, 14'h20, 8'h00, '0, 0);
    idle();
    w = init_word(14'h20);
    w[31:0] = 32'hDEAD_BEEF;
    chk("load_after_store", ref_read(32'h20), w);

    // Fetch withdraws while data keeps winning.
    cyc(1, 14'h50, 1, 14'h60, '0, '0, 0);
    cyc(1, 14'h50, 1, 14'h61, '0, '0, 0);
    cyc(0, '0, 1, 14'h62, '0, '0, 0);
    chk("withdraw_starve", 64'(dut.starve_cnt), 0);
    idle();

    // Reset arriving with a read response in flight.
    cyc(0, '0, 1, 14'h05, '0, '0, 0);
    cyc(0, '0, 1, 14'h05, '0, '0, 1);
    idle();
    idle();

    // Interleaved uncontested fetch and data reads, back to back.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cyc(1, 14'h1, 0, '0, '0, '0, 0);
      else            cyc(0, '0, 1, 14'h2, '0, '0, 0);
    end
    idle();

    // Randomized traffic honouring the hold-until-grant rule, with occasional
    // withdrawals and resets.
    pi = 0; pd = 0; ai = '0; ad = '0; we_r = '0; wd_r = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pi && $urandom_range(0, 2) != 0) begin
        pi = 1; ai = 14'($urandom_range(0, 15));
      end else if (pi && $urandom_range(0, 7) == 0) begin
        pi = 0;
      end
      if (!pd && $urandom_range(0, 2) != 0) begin
        pd = 1; ad = 14'($urandom_range(0, 15));
        we_r = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
        wd_r = {$urandom, $urandom};
      end else if (pd && $urandom_range(0, 7) == 0) begin
        pd = 0;
      end
      if ($urandom_range(0, 63) == 0) begin
        cyc(pi, ai, pd, ad, we_r, wd_r, 1);
      end else begin
        cyc(pi, ai, pd, ad, we_r, wd_r, 0);
        if (g_if) pi = 0;
        if (g_d) pd = 0;
      end
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
